lc3_controller: RTL
===================

# lc3_controller

Multi-cycle sequencer for the LC-3 core. It steps each instruction through fetch, decode, execute, memory and write-back, and issues the one-cycle `fetch_start` pulse plus opcode that make the `fetch` unit compute the next PC. It also owns the single memory port, switching it between instruction fetch (PC address) and data access (computed address).

## Interface
- `MEM_WAIT_MAX`, default 15: maximum cycles to wait for `mem_rdy` before declaring a bus fault.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `run`  in  1: level input; high allows the controller to leave IDLE and start the next instruction.
- `instr_in`  in  16: memory read data; captured as the instruction in FETCH when `mem_rdy`=1.
- `mem_rdy`  in  1: memory handshake; access completes on a cycle where `mem_req`=1 and `mem_rdy`=1.
- `fetch_start`  out  1: one-cycle pulse to the fetch unit.
- `opcode_out`  out  4: IR[15:12], held stable while `fetch_start` is high.
- `ir`  out  16: instruction register.
- `mem_req`  out  1: memory access request.
- `mem_we`  out  1: write strobe, valid only with `mem_req`.
- `mem_sel`  out  1: address select; 0 = PC, 1 = data address.
- `alu_en`  out  1: execute strobe.
- `reg_we`  out  1: register-file write.
- `cc_we`  out  1: NZP condition-code update.
- `halted`  out  1: core stopped.
- `fault`  out  2: 0 none, 1 illegal opcode, 2 bus timeout.
- `instr_count`  out  16: count of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM1, MEM2, WB, PC_UPD, HALT.
- **IDLE**
  - All strobes are low.
  - Moves to FETCH when `run`=1.
- **FETCH**
  - Drives `mem_req`=1, `mem_sel`=0.
  - On `mem_rdy`: captures `ir`←`instr_in` and moves to DECODE.
- **DECODE**
  - Classifies the opcode.
  - RTI (1000) and reserved (1101): `fault`=1, move to HALT.
  - TRAP (1111) with IR[7:0]=0x25: move to HALT, `fault`=0.
  - All other opcodes: move to EXEC.
- **EXEC**
  - `alu_en`=1 for one cycle.
  - LD, LDR, LDI, ST, STR, STI go to MEM1. All others go to WB.
- **MEM1**
  - Drives `mem_req`=1, `mem_sel`=1.
  - `mem_we`=1 for ST and STR only.
  - LDI and STI do an indirect read here (`mem_we`=0) and then go to MEM2.
  - Other memory opcodes go to WB on `mem_rdy`.
- **MEM2**
  - LDI/STI final access: read for LDI, write for STI.
  - Moves to WB on `mem_rdy`.
- **WB**
  - `reg_we`=1 for ADD, AND, NOT, LEA, LD, LDR, LDI, JSR, and TRAP (write to R7).
  - `cc_we`=1 for ADD, AND, NOT, LD, LDR, LDI. LEA does not set condition codes.
  - Stores, BR and JMP assert no write.
- **PC_UPD**
  - `fetch_start`=1 with `opcode_out`=IR[15:12].
  - `instr_count` increments.
  - Moves to FETCH if `run`=1, otherwise IDLE.
- **HALT**
  - `halted`=1.
  - Held until `rst`; `run` is ignored.
- Bus timeout: a wait counter counts cycles with `mem_req`=1 and `mem_rdy`=0. When it reaches `MEM_WAIT_MAX`: `fault`=2, move to HALT. The counter clears when each access completes.
- `instr_count` wraps from 0xFFFF to 0x0000.

## Timing
- Reset values: state IDLE; `ir`, `instr_count`, `fault` = 0; every strobe and `halted` = 0. Reset takes effect immediately (asynchronous).
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs except `mem_rdy` → state transition.
- Latency with zero-wait memory:
  - ALU, LEA, BR, JMP, JSR, TRAP: 5 cycles (FETCH, DECODE, EXEC, WB, PC_UPD).
  - LD, LDR, ST, STR: 6 cycles.
  - LDI, STI: 7 cycles.
- Each memory wait cycle adds one cycle.
- `fetch_start` is high for exactly one cycle per retired instruction. The next FETCH begins the cycle after, by which time the fetch unit's `pc` is valid.
- `run` falling mid-instruction: the current instruction completes; the controller returns to IDLE after PC_UPD.
- `rst` asserted during a memory access: `mem_req` drops asynchronously and no write completes afterwards.
- `mem_rdy` high outside an access: ignored.

## Structure
- Shared package `lc3_pkg`:
  - Opcode localparams (OP_BR … OP_TRAP).
  - State encoding.
  - Fault codes.
  - TRAP_HALT vector (0x25).
- Sub-module `lc3_op_class`: combinational decode of the opcode into flags is_mem, is_store, is_indirect, writes_reg, sets_cc, is_illegal. Reused by the bench's reference model.
- Controller top: FSM plus wait counter plus instruction counter.

## Test plan
- ADD (0x1261), `run`=1, `mem_rdy` tied high → `fetch_start` pulses in cycle 5 with `opcode_out`=0001; `reg_we`=`cc_we`=1 in cycle 4; `instr_count`=1.
- LEA (0xE002) → `reg_we`=1, `cc_we`=0, no data `mem_req`; STI (0xB001) → MEM1 read, then MEM2 with `mem_we`=1; `fetch_start` in cycle 7.
- LD with `mem_rdy` delayed 3 cycles → `mem_req`, `mem_sel`=1 held for 4 cycles; total 9 cycles; no `reg_we` before the data arrives.
- TRAP 0xF025 → `halted`=1 after DECODE, `fault`=0, no `fetch_start`; opcode 0xD000 → `fault`=1, `halted`=1.
- `mem_rdy` stuck at 0 during FETCH → after `MEM_WAIT_MAX` (15) cycles `fault`=2, `halted`=1.
- `rst` pulsed while in MEM1 of an ST → all outputs 0 immediately; state IDLE; `instr_count` = 0.

Source files
------------

// File: rtl/lc3_pkg.sv
// lc3_pkg: shared definitions for the LC-3 controller slice.
//   - opcode values (IR[15:12])
//   - controller state encoding
//   - fault codes reported on lc3_controller.fault
//   - TRAP vector that stops the core
package lc3_pkg;

   localparam logic [3:0] OP_BR   = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_LD   = 4'h2;
   localparam logic [3:0] OP_ST   = 4'h3;
   localparam logic [3:0] OP_JSR  = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_LDR  = 4'h6;
   localparam logic [3:0] OP_STR  = 4'h7;
   localparam logic [3:0] OP_RTI  = 4'h8;
   localparam logic [3:0] OP_NOT  = 4'h9;
   localparam logic [3:0] OP_LDI  = 4'hA;
   localparam logic [3:0] OP_STI  = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_RES  = 4'hD;
   localparam logic [3:0] OP_LEA  = 4'hE;
   localparam logic [3:0] OP_TRAP = 4'hF;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM1,
      S_MEM2,
      S_WB,
      S_PC_UPD,
      S_HALT
   } state_t;

   localparam logic [1:0] FAULT_NONE    = 2'd0;
   localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
   localparam logic [1:0] FAULT_BUS     = 2'd2;

   localparam logic [7:0] TRAP_HALT = 8'h25;

endpackage

// File: rtl/lc3_op_class.sv
// lc3_op_class: combinational opcode classifier.
//   opcode      in  : IR[15:12]
//   is_mem      out : instruction performs a data memory access
//   is_store    out : final data access is a write
//   is_indirect out : LDI/STI, two data accesses (pointer read first)
//   writes_reg  out : register file written in WB
//   sets_cc     out : NZP updated in WB
//   is_illegal  out : RTI or reserved opcode
module lc3_op_class
   import lc3_pkg::*;
(
   input  logic [3:0] opcode,
   output logic       is_mem,
   output logic       is_store,
   output logic       is_indirect,
   output logic       writes_reg,
   output logic       sets_cc,
   output logic       is_illegal
);

   always_comb begin
      is_mem      = 1'b0;
      is_store    = 1'b0;
      is_indirect = 1'b0;
      writes_reg  = 1'b0;
      sets_cc     = 1'b0;
      is_illegal  = 1'b0;
      case (opcode)
         OP_ADD, OP_AND, OP_NOT: begin
            writes_reg = 1'b1;
            sets_cc    = 1'b1;
         end
         OP_LD, OP_LDR: begin
            is_mem     = 1'b1;
            writes_reg = 1'b1;
            sets_cc    = 1'b1;
         end
         OP_LDI: begin
            is_mem      = 1'b1;
            is_indirect = 1'b1;
            writes_reg  = 1'b1;
            sets_cc     = 1'b1;
         end
         OP_ST, OP_STR: begin
            is_mem   = 1'b1;
            is_store = 1'b1;
         end
         OP_STI: begin
            is_mem      = 1'b1;
            is_store    = 1'b1;
            is_indirect = 1'b1;
         end
         OP_LEA, OP_JSR, OP_TRAP: writes_reg = 1'b1;
         OP_RTI, OP_RES:          is_illegal = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/lc3_controller.sv
// lc3_controller: multi-cycle LC-3 sequencer and memory-port owner.
//   clk, rst (async, active high), run (level: allow next instruction)
//   instr_in, mem_rdy          : memory read data / handshake
//   mem_req, mem_we, mem_sel   : memory port control (sel 0 = PC, 1 = data)
//   fetch_start, opcode_out    : one-cycle pulse + opcode to the fetch unit
//   ir                         : instruction register
//   alu_en, reg_we, cc_we      : datapath strobes
//   halted, fault              : stop indication (fault 0 none, 1 illegal, 2 bus)
//   instr_count                : retired instruction count (wraps)
// All outputs depend on registered state only.
module lc3_controller
   import lc3_pkg::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic [15:0] instr_in,
   input  logic        mem_rdy,
   output logic        fetch_start,
   output logic [3:0]  opcode_out,
   output logic [15:0] ir,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_sel,
   output logic        alu_en,
   output logic        reg_we,
   output logic        cc_we,
   output logic        halted,
   output logic [1:0]  fault,
   output logic [15:0] instr_count
);

   localparam int unsigned WW = $clog2(MEM_WAIT_MAX + 1);

   state_t        state, state_nx;
   logic [1:0]    fault_nx;
   logic [WW-1:0] wait_cnt;
   logic          access;
   logic          timeout;
   logic          is_mem, is_store, is_indirect, writes_reg, sets_cc, is_illegal;

   lc3_op_class u_op_class (
      .opcode      (ir[15:12]),
      .is_mem      (is_mem),
      .is_store    (is_store),
      .is_indirect (is_indirect),
      .writes_reg  (writes_reg),
      .sets_cc     (sets_cc),
      .is_illegal  (is_illegal)
   );

   assign access     = (state == S_FETCH) || (state == S_MEM1) || (state == S_MEM2);
   // Fires on the MEM_WAIT_MAX-th consecutive not-ready cycle of one access.
   assign timeout    = access && !mem_rdy && (wait_cnt == WW'(MEM_WAIT_MAX - 1));
   assign opcode_out = ir[15:12];

   always_comb begin
      state_nx    = state;
      fault_nx    = fault;
      mem_req     = access;
      mem_sel     = (state == S_MEM1) || (state == S_MEM2);
      mem_we      = ((state == S_MEM1) && is_store && !is_indirect) ||
                    ((state == S_MEM2) && is_store);
      alu_en      = (state == S_EXEC);
      reg_we      = (state == S_WB) && writes_reg;
      cc_we       = (state == S_WB) && sets_cc;
      fetch_start = (state == S_PC_UPD);
      halted      = (state == S_HALT);
      case (state)
         S_IDLE:   if (run) state_nx = S_FETCH;
         S_FETCH: begin
            if (mem_rdy) begin
               state_nx = S_DECODE;
            end else if (timeout) begin
               state_nx = S_HALT;
               fault_nx = FAULT_BUS;
            end
         end
         S_DECODE: begin
            if (is_illegal) begin
               state_nx = S_HALT;
               fault_nx = FAULT_ILLEGAL;
            end else if ((ir[15:12] == OP_TRAP) && (ir[7:0] == TRAP_HALT)) begin
               state_nx = S_HALT;
            end else begin
               state_nx = S_EXEC;
            end
         end
         S_EXEC:   state_nx = is_mem ? S_MEM1 : S_WB;
         S_MEM1: begin
            if (mem_rdy) begin
               state_nx = is_indirect ? S_MEM2 : S_WB;
            end else if (timeout) begin
               state_nx = S_HALT;
               fault_nx = FAULT_BUS;
            end
         end
         S_MEM2: begin
            if (mem_rdy) begin
               state_nx = S_WB;
            end else if (timeout) begin
               state_nx = S_HALT;
               fault_nx = FAULT_BUS;
            end
         end
         S_WB:     state_nx = S_PC_UPD;
         S_PC_UPD: state_nx = run ? S_FETCH : S_IDLE;
         S_HALT:   state_nx = S_HALT;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         fault       <= FAULT_NONE;
         ir          <= '0;
         wait_cnt    <= '0;
         instr_count <= '0;
      end else begin
         state <= state_nx;
         fault <= fault_nx;
         if ((state == S_FETCH) && mem_rdy)
            ir <= instr_in;
         if (access && !mem_rdy)
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
         if (state == S_PC_UPD)
            instr_count <= instr_count + 16'd1;
      end
   end

endmodule
